// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl
// Purpose  : Sits between the single-cycle datapath and the 32x32 register
//            file. After reset it zeroes registers 1..NUM_REGS-1 by walking the
//            write port. It then passes the core's register-file controls
//            through unchanged. A debug requester can stall the core, do one
//            read with an optional write, and get the old value back over a
//            four-phase req/ack handshake.
// Ports    : Clk, Reset            - clock, synchronous active-high reset
//            CoreRA/RB/RW/BusW/RegWr - core register-file controls (inputs)
//            Stall, Ready          - core hold request, sweep-done flag
//            DbgReq/DbgWr/DbgAddr/DbgWData - debug request side (inputs)
//            DbgAck, DbgRData      - debug acknowledge, pre-write read data
//            RA/RB/RW/BusW/RegWr   - to the register file
//            BusA                  - combinational read data from RA
// Revision : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl #(
    parameter int NUM_REGS       = 32,
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] CoreRA,
    input  logic [ADDR_W-1:0] CoreRB,
    input  logic [ADDR_W-1:0] CoreRW,
    input  logic [DATA_W-1:0] CoreBusW,
    input  logic              CoreRegWr,
    output logic              Stall,
    output logic              Ready,
    input  logic              DbgReq,
    input  logic              DbgWr,
    input  logic [ADDR_W-1:0] DbgAddr,
    input  logic [DATA_W-1:0] DbgWData,
    output logic              DbgAck,
    output logic [DATA_W-1:0] DbgRData,
    output logic [ADDR_W-1:0] RA,
    output logic [ADDR_W-1:0] RB,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    output logic              RegWr,
    input  logic [DATA_W-1:0] BusA
);

    localparam logic [2:0] c_stClear  = 3'd0;
    localparam logic [2:0] c_stRun    = 3'd1;
    localparam logic [2:0] c_stHalt   = 3'd2;
    localparam logic [2:0] c_stAccess = 3'd3;
    localparam logic [2:0] c_stAck    = 3'd4;

    localparam logic [2:0]        c_resetState = CLEAR_ON_RESET ? c_stClear : c_stRun;
    localparam logic [ADDR_W-1:0] c_lastReg    = ADDR_W'(NUM_REGS - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_nextState;
    logic [ADDR_W-1:0] r_clearCnt;
    logic              r_dbgAck;
    logic [DATA_W-1:0] r_dbgRData;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= c_resetState;
            r_clearCnt <= ADDR_W'(1);
            r_dbgAck   <= 1'b0;
            r_dbgRData <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == c_stClear) begin
                r_clearCnt <= r_clearCnt + ADDR_W'(1);
            end
            // BusA still shows the old contents at this edge, so the captured
            // value is the pre-write one even when the debug write commits.
            if (r_state == c_stAccess) begin
                r_dbgAck   <= 1'b1;
                r_dbgRData <= BusA;
            end else if ((r_state == c_stAck) && !DbgReq) begin
                r_dbgAck <= 1'b0;
            end
        end
    end

    // Stall and the port mux depend on state only; DbgReq only steers the
    // next state, so there is no combinational DbgReq -> Stall path.
    always_comb begin
        w_nextState = r_state;
        Stall       = 1'b1;
        RA          = '0;
        RB          = '0;
        RW          = '0;
        BusW        = '0;
        RegWr       = 1'b0;
        case (r_state)
            c_stClear: begin
                RW    = r_clearCnt;
                RegWr = 1'b1;
                if (r_clearCnt == c_lastReg) begin
                    w_nextState = c_stRun;
                end
            end
            c_stRun: begin
                Stall = 1'b0;
                RA    = CoreRA;
                RB    = CoreRB;
                RW    = CoreRW;
                BusW  = CoreBusW;
                RegWr = CoreRegWr;
                if (DbgReq) begin
                    w_nextState = c_stHalt;
                end
            end
            // One idle stalled cycle so the core sees Stall before the
            // register-file ports are taken over.
            c_stHalt: begin
                w_nextState = c_stAccess;
            end
            c_stAccess: begin
                RA          = DbgAddr;
                RW          = DbgAddr;
                BusW        = DbgWData;
                RegWr       = DbgWr;
                w_nextState = c_stAck;
            end
            c_stAck: begin
                if (!DbgReq) begin
                    w_nextState = c_stRun;
                end
            end
            default: begin
                w_nextState = c_resetState;
            end
        endcase
    end

    assign Ready    = (r_state != c_stClear);
    assign DbgAck   = r_dbgAck;
    assign DbgRData = r_dbgRData;

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_access_ctrl
// Purpose  : Self-checking bench for regfile_access_ctrl. Includes a simple
//            register file model and an array-based reference model. Debug
//            responses go through a scoreboard queue that a separate monitor
//            drains on each rising DbgAck.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_access_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] CoreRA = '0, CoreRB = '0, CoreRW = '0;
    logic [DW-1:0] CoreBusW = '0;
    logic          CoreRegWr = 1'b0;
    logic          Stall, Ready;
    logic          DbgReq = 1'b0, DbgWr = 1'b0;
    logic [AW-1:0] DbgAddr = '0;
    logic [DW-1:0] DbgWData = '0;
    logic          DbgAck;
    logic [DW-1:0] DbgRData;
    logic [AW-1:0] RA, RB, RW;
    logic [DW-1:0] BusW, BusA, BusB;
    logic          RegWr;

    regfile_access_ctrl dut (
        .Clk(Clk), .Reset(Reset),
        .CoreRA(CoreRA), .CoreRB(CoreRB), .CoreRW(CoreRW),
        .CoreBusW(CoreBusW), .CoreRegWr(CoreRegWr),
        .Stall(Stall), .Ready(Ready),
        .DbgReq(DbgReq), .DbgWr(DbgWr), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
        .DbgAck(DbgAck), .DbgRData(DbgRData),
        .RA(RA), .RB(RB), .RW(RW), .BusW(BusW), .RegWr(RegWr),
        .BusA(BusA)
    );

    always #5 Clk = ~Clk;

    // Register file model: $0 reads as zero and discards writes.
    logic          rfPreload = 1'b0;
    logic [DW-1:0] rf [32];
    always @(posedge Clk) begin
        if (rfPreload) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i);
        end else if (RegWr && (RW != 0)) begin
            rf[RW] <= BusW;
        end
    end
    assign BusA = (RA == 0) ? '0 : rf[RA];
    assign BusB = (RB == 0) ? '0 : rf[RB];

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] refRegs [32];
    logic [DW-1:0] sbQ [$];
    logic          prevAck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each new acknowledge must carry the oldest outstanding answer.
    always @(negedge Clk) begin
        if (DbgAck && !prevAck) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dbg_unexpected_ack: got ack with rdata 0x%0h, expected none", DbgRData);
            end else begin
                check("dbg_rdata", DbgRData, sbQ.pop_front());
            end
        end
        prevAck = DbgAck;
    end

    task automatic coreCycle(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                             input logic [AW-1:0] rw, input logic [DW-1:0] w, input logic we);
        @(negedge Clk);
        CoreRA = ra; CoreRB = rb; CoreRW = rw; CoreBusW = w; CoreRegWr = we;
        #1;
        check("core_busA", BusA, refRegs[ra]);
        check("core_busB", BusB, refRegs[rb]);
        check("run_stall", 32'(Stall), 32'd0);
        check("run_regwr", 32'(RegWr), 32'(we));
        check("run_rw", 32'(RW), 32'(rw));
        if (we && (rw != 0)) refRegs[rw] = w;
    endtask

    task automatic dbgTxn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                          input logic collide, input logic [DW-1:0] colW, input int hold);
        @(negedge Clk);
        DbgReq = 1'b1; DbgAddr = addr; DbgWr = wr; DbgWData = wdata;
        CoreRA = addr; CoreRB = '0; CoreRW = addr; CoreBusW = colW; CoreRegWr = collide;
        #1;
        check("req_cycle_stall", 32'(Stall), 32'd0);
        if (collide && (addr != 0)) refRegs[addr] = colW;
        sbQ.push_back(refRegs[addr]);
        if (wr && (addr != 0)) refRegs[addr] = wdata;
        // HALT: core inputs become garbage that must never reach the file
        @(negedge Clk);
        CoreRegWr = 1'b1; CoreRW = 5'($urandom_range(1, 31)); CoreBusW = $urandom;
        #1;
        check("halt_stall", 32'(Stall), 32'd1);
        check("halt_regwr", 32'(RegWr), 32'd0);
        check("halt_ack", 32'(DbgAck), 32'd0);
        // ACCESS
        @(negedge Clk);
        CoreRW = 5'($urandom_range(1, 31)); CoreBusW = $urandom;
        #1;
        check("access_stall", 32'(Stall), 32'd1);
        check("access_regwr", 32'(RegWr), 32'(wr));
        check("access_rw", 32'(RW), 32'(addr));
        check("access_ack", 32'(DbgAck), 32'd0);
        // ACK
        @(negedge Clk);
        #1;
        check("ack_latency", 32'(DbgAck), 32'd1);
        check("ack_stall", 32'(Stall), 32'd1);
        check("ack_regwr", 32'(RegWr), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            #1;
            check("ack_hold_stall", 32'(Stall), 32'd1);
            check("ack_hold_ack", 32'(DbgAck), 32'd1);
        end
        DbgReq = 1'b0;
        CoreRegWr = 1'b0;
        @(negedge Clk);
        #1;
        check("release_stall", 32'(Stall), 32'd0);
        check("release_ack", 32'(DbgAck), 32'd0);
    endtask

    initial begin
        int k;
        logic [AW-1:0] a;
        logic [DW-1:0] w;

        // Preload n<-n, then one final reset edge with the preload released.
        Reset = 1'b1; rfPreload = 1'b1;
        repeat (3) @(negedge Clk);
        rfPreload = 1'b0;
        @(negedge Clk);
        #1;
        check("reset_ack", 32'(DbgAck), 32'd0);
        check("reset_rdata", DbgRData, 32'd0);
        check("reset_stall", 32'(Stall), 32'd1);
        check("reset_ready", 32'(Ready), 32'd0);
        Reset = 1'b0;
        for (k = 2; k <= 32; k++) begin
            @(negedge Clk);
            #1;
            check("sweep_ready", 32'(Ready), (k <= 31) ? 32'd0 : 32'd1);
            check("sweep_stall", 32'(Stall), (k <= 31) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 32; i++) refRegs[i] = '0;
        for (int i = 0; i < 32; i++) coreCycle(5'(i), 5'(31 - i), '0, '0, 1'b0);

        // Core passthrough
        coreCycle('0, '0, 5'd5, 32'h12345678, 1'b1);
        coreCycle(5'd5, '0, 5'd3, 32'hCAFEF00D, 1'b0);
        coreCycle(5'd3, 5'd5, '0, '0, 1'b0);

        // Debug read-modify of reg7
        coreCycle('0, '0, 5'd7, 32'h7, 1'b1);
        dbgTxn(5'd7, 1'b1, 32'hDEADBEEF, 1'b0, '0, 2);
        coreCycle(5'd7, '0, '0, '0, 1'b0);

        // Debug to $0
        dbgTxn(5'd0, 1'b1, 32'hFFFFFFFF, 1'b0, '0, 0);
        coreCycle(5'd0, 5'd0, '0, '0, 1'b0);

        // Collision: core writes reg9 in the request cycle
        dbgTxn(5'd9, 1'b0, 32'h0, 1'b1, 32'h99, 1);
        coreCycle(5'd9, '0, '0, '0, 1'b0);

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0)
                dbgTxn(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                       1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)));
            else
                coreCycle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset during ACK with DbgReq held high
        a = 5'($urandom_range(1, 31));
        w = $urandom;
        @(negedge Clk);
        DbgReq = 1'b1; DbgAddr = a; DbgWr = 1'b1; DbgWData = w; CoreRegWr = 1'b0;
        sbQ.push_back(refRegs[a]);
        repeat (3) @(negedge Clk);
        #1;
        check("mid_ack_before_reset", 32'(DbgAck), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        check("mid_reset_ack", 32'(DbgAck), 32'd0);
        check("mid_reset_stall", 32'(Stall), 32'd1);
        check("mid_reset_ready", 32'(Ready), 32'd0);
        Reset = 1'b0;
        for (int i = 0; i < 32; i++) refRegs[i] = '0;
        sbQ.push_back(32'd0);
        refRegs[a] = w;
        k = 1;
        while (!DbgAck && (k < 80)) begin
            @(negedge Clk);
            #1;
            k++;
        end
        check("reservice_cycle", 32'(k), 32'd35);
        DbgReq = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < 32; i++) coreCycle(5'(i), 5'($urandom_range(0, 31)), '0, '0, 1'b0);

        @(negedge Clk);
        check("sb_empty", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Sequencer and arbiter for the 32×32 `RegisterFile`, placed between the single-cycle datapath and the register file ports. After reset it clears registers $1–$31 by sweeping the write port. It then passes the core's RA/RB/RW/BusW/RegWr through unchanged. When a debug requester asks for access, it stalls the core, performs one debug read-and-optional-write, and returns the result over a four-phase req/ack handshake.

## Interface
- NUM_REGS, 32, register count; the clear sweep covers 1..NUM_REGS-1
- ADDR_W, 5, register address width
- DATA_W, 32, data width
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = go straight to RUN

- Clk  in  1  clock, rising-edge active
- Reset  in  1  synchronous, active-high reset
- CoreRA, CoreRB, CoreRW  in  ADDR_W  core read/write addresses
- CoreBusW  in  DATA_W  core write data
- CoreRegWr  in  1  core write enable
- Stall  out  1  core must hold PC/state while high
- Ready  out  1  clear sweep done, controller serviceable
- DbgReq  in  1  debug request, level, four-phase
- DbgWr  in  1  1 = write DbgWData after read
- DbgAddr  in  ADDR_W  debug register address
- DbgWData  in  DATA_W  debug write data
- DbgAck  out  1  debug acknowledge
- DbgRData  out  DATA_W  pre-write value of DbgAddr, valid while DbgAck
- RA, RB, RW  out  ADDR_W  to RegisterFile
- BusW  out  DATA_W  to RegisterFile
- RegWr  out  1  to RegisterFile
- BusA  in  DATA_W  from RegisterFile (combinational read)

## Operation
- States: CLEAR, RUN, HALT, ACCESS, ACK. State, counter, DbgAck and DbgRData are registered; port muxing is combinational from state.
- **Reset** (sampled high at an edge):
  - state ← CLEAR (RUN if CLEAR_ON_RESET=0), clear counter ← 1.
  - Stall=1, Ready=0, DbgAck=0, DbgRData=0.
  - Reset mid-debug aborts the transaction; the write already committed in ACCESS stays.
- **CLEAR:**
  - RegWr=1, RW=counter, BusW=0, RA=RB=0, Stall=1; counter increments each cycle.
  - Leaves for RUN after the write of NUM_REGS-1: 31 write cycles, $0 never written.
  - DbgReq is ignored here but stays pending.
- **RUN:**
  - RA/RB/RW/BusW/RegWr = core inputs, Stall=0, Ready=1.
  - DbgReq=1 at an edge → HALT. The core write in that same cycle commits normally.
- **HALT:** Stall=1, RegWr=0, RA=RB=RW=0. One cycle, so the core observes the stall before the ports are stolen. → ACCESS.
- **ACCESS:**
  - RA=DbgAddr, RW=DbgAddr, BusW=DbgWData, RegWr=DbgWr, Stall=1.
  - At the edge: DbgRData ← BusA (old value), the write commits, → ACK.
- **ACK:**
  - DbgAck=1, Stall=1, RegWr=0.
  - Stays while DbgReq=1. DbgReq=0 at an edge → RUN with DbgAck=0.
- **Debug target $0:** the write is forwarded; the RegisterFile discards it, so a read-back returns 0.
- **Operand rules:** RB in the debug states is 0. Core inputs are don't-care whenever Stall=1.

## Timing
- Clear sweep: cycles 1..31 after Reset deasserts. Ready=1 from cycle 32.
- Debug latency, with DbgReq sampled high in RUN cycle N:
  - N+1 HALT
  - N+2 ACCESS
  - N+3 DbgAck=1 and DbgRData valid
- Stall timing:
  - High from N+1 through the cycle in which DbgReq is sampled low in ACK.
  - Low in the following RUN cycle.
- Back-to-back requests: DbgReq must drop before re-assertion. Minimum RUN gap is one cycle, so the core gets at least one cycle between debug accesses.
- No combinational path from DbgReq to Stall; Stall is state-decoded only.

## Test plan
- **Reset sweep:** preload regs n←n, Reset 1 cycle. Expect:
  - Ready=0 for 31 cycles, then Ready=1 and Stall=0.
  - All regs 1–31 read 0 via core RA/RB.
- **Core passthrough:** in RUN, CoreRW=5, CoreBusW=0x12345678, CoreRegWr=1. Expect:
  - CoreRA=5 gives BusA=0x12345678 next cycle.
  - With CoreRegWr=0 and CoreRW=3, reg3 is unchanged.
- **Debug read-modify:** reg7=0x7; DbgReq, DbgWr=1, DbgAddr=7, DbgWData=0xDEADBEEF. Expect:
  - DbgAck at N+3 with DbgRData=0x7.
  - Reg7=0xDEADBEEF afterwards.
  - Stall held until DbgReq drops.
- **Debug to $0:** DbgWr=1, DbgAddr=0, DbgWData=0xFFFFFFFF. Expect DbgRData=0, and a later read of $0 returns 0.
- **Collision:** DbgReq rises in the same cycle as a core write to reg9=0x99, with a debug read of reg9. Expect:
  - DbgRData=0x99, showing the core write committed first.
  - No core write lands while Stall=1.
- **Reset mid-debug:** assert Reset during ACK. Expect:
  - Next cycle DbgAck=0, Stall=1, Ready=0.
  - The sweep reruns and debug is reserviced after it if DbgReq is still high.
